// File: rtl/pipe_pkg.sv
// Shared pipeline constants: NOP encoding, per-boundary payload widths and occupancy states.
package pipe_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   // pc_plus4 + instr; the later boundaries carry decoded operands and control
   localparam int unsigned IF_ID_W  = 64;
   localparam int unsigned ID_EX_W  = 149;
   localparam int unsigned EX_MEM_W = 77;
   localparam int unsigned MEM_WB_W = 73;

   typedef enum logic [1:0] {
      OccEmpty = 2'd0,
      OccOne   = 2'd1,
      OccFull  = 2'd2
   } occ_e;

endpackage

// File: rtl/pipe_bubble_counter.sv
// Saturating up-counter used to count cycles where a stage presents no valid output.
module pipe_bubble_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (en && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready handshake, stall/flush and optional skid entry.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned          WIDTH     = 64,
   parameter logic [WIDTH-1:0]     NOP_VALUE = WIDTH'({32'd0, NOP_INSTR}),
   parameter bit                   SKID      = 1'b1,
   parameter int unsigned          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] bubble_cnt
);

   occ_e             occ_q, occ_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             live_q;
   logic             accept;
   logic             rel;

   // live_q keeps in_ready low until the first edge after reset is released
   generate
      if (SKID) begin : g_skid
         assign in_ready = live_q & !stall & (occ_q != OccFull);
      end else begin : g_single
         assign in_ready = live_q & !stall & ((occ_q == OccEmpty) | out_ready);
      end
   endgenerate

   assign out_valid = (occ_q != OccEmpty) & !stall;
   assign accept    = in_valid & in_ready;
   assign rel       = out_valid & out_ready;

   always_comb begin
      occ_d  = occ_q;
      main_d = main_q;
      skid_d = skid_q;
      if (flush) begin
         occ_d  = OccEmpty;
         main_d = NOP_VALUE;
         skid_d = NOP_VALUE;
      end else begin
         case (occ_q)
            OccEmpty: begin
               if (accept) begin
                  occ_d  = OccOne;
                  main_d = in_data;
               end
            end
            OccOne: begin
               if (accept && rel) begin
                  main_d = in_data;
               end else if (rel) begin
                  occ_d  = OccEmpty;
                  main_d = NOP_VALUE;
               end else if (accept && SKID) begin
                  occ_d  = OccFull;
                  skid_d = in_data;
               end
            end
            OccFull: begin
               if (rel) begin
                  occ_d  = OccOne;
                  main_d = skid_q;
                  skid_d = NOP_VALUE;
               end
            end
            default: begin
               occ_d  = OccEmpty;
               main_d = NOP_VALUE;
               skid_d = NOP_VALUE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         occ_q  <= OccEmpty;
         main_q <= NOP_VALUE;
         skid_q <= NOP_VALUE;
         live_q <= 1'b0;
      end else begin
         occ_q  <= occ_d;
         main_q <= main_d;
         skid_q <= skid_d;
         live_q <= 1'b1;
      end
   end

   assign out_data  = main_q;
   assign occupancy = occ_q;

   pipe_bubble_counter #(
      .CNT_W (CNT_W)
   ) u_bubble_counter (
      .clk   (clk),
      .reset (reset),
      .en    (!out_valid),
      .count (bubble_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: vector table on a skid stage, plus reset, saturation and single-entry sequences.
module tb_pipe_stage_reg;

   localparam logic [63:0] NOP = 64'h0000_0000_0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, flush, in_valid, out_ready;
   logic [63:0] in_data;
   logic        in_ready, out_valid;
   logic [63:0] out_data;
   logic [1:0]  occupancy;
   logic [15:0] bubble_cnt;

   logic        s_stall, s_flush, s_in_valid, s_out_ready;
   logic [63:0] s_in_data;
   logic        s_in_ready, s_out_valid;
   logic [63:0] s_out_data;
   logic [1:0]  s_occupancy;
   logic [3:0]  s_bubble_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(
      .WIDTH (64),
      .SKID  (1'b1),
      .CNT_W (16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .occupancy  (occupancy),
      .bubble_cnt (bubble_cnt)
   );

   pipe_stage_reg #(
      .WIDTH (64),
      .SKID  (1'b0),
      .CNT_W (4)
   ) dut_single (
      .clk        (clk),
      .reset      (reset),
      .stall      (s_stall),
      .flush      (s_flush),
      .in_valid   (s_in_valid),
      .in_ready   (s_in_ready),
      .in_data    (s_in_data),
      .out_valid  (s_out_valid),
      .out_ready  (s_out_ready),
      .out_data   (s_out_data),
      .occupancy  (s_occupancy),
      .bubble_cnt (s_bubble_cnt)
   );

   typedef struct {
      logic        iv;
      logic [63:0] d;
      logic        ordy;
      logic        st;
      logic        fl;
      logic        e_ov;
      logic [63:0] e_od;
      logic [1:0]  e_occ;
      logic        e_ir;
   } vec_t;

   vec_t tbl[24];

   function automatic vec_t mk(logic iv, logic [63:0] d, logic ordy, logic st, logic fl,
                               logic e_ov, logic [63:0] e_od, logic [1:0] e_occ, logic e_ir);
      vec_t v;
      v.iv = iv; v.d = d; v.ordy = ordy; v.st = st; v.fl = fl;
      v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ; v.e_ir = e_ir;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] exp_bub;

      // streaming
      tbl[0]  = mk(1, 64'h1,  1, 0, 0, 0, NOP,    0, 1);
      tbl[1]  = mk(1, 64'h2,  1, 0, 0, 1, 64'h1,  1, 1);
      tbl[2]  = mk(1, 64'h3,  1, 0, 0, 1, 64'h2,  1, 1);
      tbl[3]  = mk(0, 64'h0,  1, 0, 0, 1, 64'h3,  1, 1);
      tbl[4]  = mk(0, 64'h0,  0, 0, 0, 0, NOP,    0, 1);
      // backpressure into the skid entry
      tbl[5]  = mk(1, 64'hA,  0, 0, 0, 0, NOP,    0, 1);
      tbl[6]  = mk(1, 64'hB,  0, 0, 0, 1, 64'hA,  1, 1);
      tbl[7]  = mk(1, 64'hC,  0, 0, 0, 1, 64'hA,  2, 0);
      tbl[8]  = mk(0, 64'h0,  1, 0, 0, 1, 64'hA,  2, 0);
      tbl[9]  = mk(0, 64'h0,  1, 0, 0, 1, 64'hB,  1, 1);
      tbl[10] = mk(0, 64'h0,  0, 0, 0, 0, NOP,    0, 1);
      // stall holds X for three cycles
      tbl[11] = mk(1, 64'h55, 0, 0, 0, 0, NOP,    0, 1);
      tbl[12] = mk(1, 64'h66, 1, 1, 0, 0, 64'h55, 1, 0);
      tbl[13] = mk(1, 64'h66, 1, 1, 0, 0, 64'h55, 1, 0);
      tbl[14] = mk(1, 64'h66, 1, 1, 0, 0, 64'h55, 1, 0);
      tbl[15] = mk(0, 64'h0,  1, 0, 0, 1, 64'h55, 1, 1);
      tbl[16] = mk(0, 64'h0,  0, 0, 0, 0, NOP,    0, 1);
      // flush with stall while full; Y must never appear
      tbl[17] = mk(1, 64'h71, 0, 0, 0, 0, NOP,    0, 1);
      tbl[18] = mk(1, 64'h72, 0, 0, 0, 1, 64'h71, 1, 1);
      tbl[19] = mk(1, 64'h99, 0, 1, 1, 0, 64'h71, 2, 0);
      tbl[20] = mk(0, 64'h0,  1, 0, 0, 0, NOP,    0, 1);
      tbl[21] = mk(0, 64'h0,  1, 0, 0, 0, NOP,    0, 1);
      // flush discards a same-cycle accept
      tbl[22] = mk(1, 64'h88, 0, 0, 1, 0, NOP,    0, 1);
      tbl[23] = mk(0, 64'h0,  1, 0, 0, 0, NOP,    0, 1);

      reset = 1'b0;
      stall = 0; flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
      s_stall = 0; s_flush = 0; s_in_valid = 0; s_out_ready = 0; s_in_data = '0;

      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("post-reset in_ready low", 64'(in_ready), 64'd0);
      chk("post-reset out_data", out_data, NOP);
      @(posedge clk);
      #1;
      chk("first-edge in_ready", 64'(in_ready), 64'd1);
      exp_bub = 16'd1;

      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         in_valid  = tbl[i].iv;
         in_data   = tbl[i].d;
         out_ready = tbl[i].ordy;
         stall     = tbl[i].st;
         flush     = tbl[i].fl;
         #1;
         chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
         chk($sformatf("v%0d out_data", i), out_data, tbl[i].e_od);
         chk($sformatf("v%0d occupancy", i), 64'(occupancy), 64'(tbl[i].e_occ));
         chk($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(tbl[i].e_ir));
         chk($sformatf("v%0d bubble_cnt", i), 64'(bubble_cnt), 64'(exp_bub));
         @(posedge clk);
         if (!tbl[i].e_ov) exp_bub++;
      end

      @(negedge clk);
      in_valid = 0; out_ready = 0; stall = 0; flush = 0;

      // single-entry stage has seen more than 15 idle edges
      #1;
      chk("sat bubble_cnt", 64'(s_bubble_cnt), 64'd15);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("sat bubble_cnt holds", 64'(s_bubble_cnt), 64'd15);

      s_in_valid = 1; s_in_data = 64'h21; s_out_ready = 0;
      #1;
      chk("s0 in_ready empty", 64'(s_in_ready), 64'd1);
      chk("s0 occupancy empty", 64'(s_occupancy), 64'd0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         s_in_data = 64'h22;
         #1;
         chk($sformatf("s0 in_ready blocked %0d", k), 64'(s_in_ready), 64'd0);
         chk($sformatf("s0 out_valid %0d", k), 64'(s_out_valid), 64'd1);
         chk($sformatf("s0 out_data held %0d", k), s_out_data, 64'h21);
         chk($sformatf("s0 occupancy <= 1 %0d", k), 64'(s_occupancy), 64'd1);
      end
      @(negedge clk);
      s_out_ready = 1;
      #1;
      chk("s0 in_ready pass-through", 64'(s_in_ready), 64'd1);
      chk("s0 out_data before swap", s_out_data, 64'h21);
      @(negedge clk);
      s_in_valid = 0;
      #1;
      chk("s0 out_data replaced", s_out_data, 64'h22);
      chk("s0 occupancy after swap", 64'(s_occupancy), 64'd1);
      @(negedge clk);
      s_out_ready = 0;
      #1;
      chk("s0 drained occupancy", 64'(s_occupancy), 64'd0);
      chk("s0 drained out_data", s_out_data, NOP);

      // asynchronous reset while the skid stage is full
      in_valid = 1; in_data = 64'hA1; out_ready = 0;
      @(negedge clk);
      in_data = 64'hA2;
      @(negedge clk);
      in_valid = 0;
      #1;
      chk("pre-reset occupancy full", 64'(occupancy), 64'd2);
      #2;
      reset = 1'b0;
      #1;
      chk("async reset out_valid", 64'(out_valid), 64'd0);
      chk("async reset out_data", out_data, NOP);
      chk("async reset occupancy", 64'(occupancy), 64'd0);
      chk("async reset in_ready", 64'(in_ready), 64'd0);
      chk("async reset bubble_cnt", 64'(bubble_cnt), 64'd0);
      @(posedge clk);
      #1;
      chk("held reset occupancy", 64'(occupancy), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("release in_ready low", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      chk("release in_ready rises", 64'(in_ready), 64'd1);
      chk("release data dropped", out_data, NOP);
      chk("release bubble_cnt", 64'(bubble_cnt), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline boundary register that replaces the fixed IF/ID-style latch at every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a WIDTH-bit payload with a valid/ready handshake and hazard-unit stall and flush controls. An optional second (skid) entry lets upstream keep full throughput when downstream ready is deasserted. It also keeps a saturating count of bubble cycles for performance monitoring.

Parameters:
WIDTH, 64, payload width in bits (e.g. pc_plus4 concatenated with instr).
NOP_VALUE, {32'd0, 32'h00000013}, payload driven while empty, after reset and after flush (instr field = addi x0,x0,0).
SKID, 1, 1 = two-entry (main + skid) buffer; 0 = single entry.
CNT_W, 16, width of the bubble counter.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset (asserted at 0).
stall  input  1  hazard-unit hold; freezes the stage.
flush  input  1  hazard-unit kill; discards all held entries.
in_valid  input  1  upstream payload valid.
in_ready  output  1  stage can accept this cycle.
in_data  input  WIDTH  upstream payload.
out_valid  output  1  output payload valid.
out_ready  input  1  downstream accepts.
out_data  output  WIDTH  head payload; NOP_VALUE when empty.
occupancy  output  2  entries held (0..2; never exceeds 1 when SKID=0).
bubble_cnt  output  CNT_W  saturating count of cycles with out_valid=0 while not in reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - Internal state: both entries invalid, skid data = NOP_VALUE, bubble_cnt = 0.
  - Outputs: out_data = NOP_VALUE, out_valid = 0, occupancy = 0, in_ready = 0.
  - After deassertion, in_ready rises on the first clock edge. Reset mid-transfer drops all data.
- State encoding via occupancy: EMPTY(0), ONE(1), FULL(2, SKID=1 only).
- Transfers: accept = in_valid & in_ready; release = out_valid & out_ready. Both are evaluated at the same posedge.
- in_ready:
  - SKID=1: !stall & (occupancy < 2). This is registered-friendly and does not depend combinationally on out_ready.
  - SKID=0: !stall & (occupancy==0 | out_ready).
- out_valid = (occupancy != 0) & !stall. out_data is always the main entry.
- Transitions (stall=0, flush=0):
  - EMPTY+accept -> ONE; in_data goes to main.
  - ONE+accept+release -> ONE; main replaced.
  - ONE+release -> EMPTY; main goes to NOP_VALUE.
  - ONE+accept, no release -> FULL (SKID=1); in_data goes to skid.
  - FULL+release -> ONE; skid moves to main, skid goes to NOP_VALUE.
  - FULL never accepts.
- Ordering: strict FIFO; zero reordering. Latency is 1 cycle from accept to out_valid when the stage is empty.
- stall=1: no accept, no release; all entries and occupancy hold; out_valid masked to 0; bubble_cnt still counts.
- flush=1: at the next edge, occupancy = 0, both entries = NOP_VALUE. A same-cycle accept is discarded. flush overrides stall. in_ready keeps its normal formula (the upstream beat is consumed and dropped).
- bubble_cnt: +1 on each edge where out_valid was 0; saturates at all-ones and does not wrap.
- Payload is never modified; no arithmetic on data.

Decomposition:
- Shared package pipe_pkg:
  - NOP_INSTR = 32'h00000013.
  - Per-boundary payload width constants: IF_ID_W = 64, ID_EX_W, EX_MEM_W, MEM_WB_W.
  - Occupancy state constants EMPTY/ONE/FULL.
- Sub-module: pipe_bubble_counter, a saturating CNT_W-bit counter with increment enable. Everything else stays in pipe_stage_reg; SKID is selected by generate.

Test Plan:
1. Reset: drive reset=0 mid-stream with occupancy=2 -> same cycle out_valid=0, out_data=NOP_VALUE (low word 32'h00000013), occupancy=0. After release, in_ready=1 on the first edge.
2. Streaming: SKID=1, out_ready=1, push payloads 1, 2, 3 on consecutive cycles -> out_data 1, 2, 3 on cycles 1, 2, 3 with out_valid=1, occupancy stays 1.
3. Backpressure: hold out_ready=0 and push A then B -> occupancy=2, in_ready=0, out_data=A. Raise out_ready -> A then B emerge in order, occupancy 2 -> 1 -> 0.
4. Stall: occupancy=1 holding X, stall=1 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, X retained, bubble_cnt +3. Drop stall -> X emitted.
5. Flush: occupancy=2, assert flush together with stall and in_valid=1 (payload Y) -> next cycle occupancy=0, out_data=NOP_VALUE, Y never appears.
6. Saturation and SKID=0: with CNT_W=4, idle 20 cycles -> bubble_cnt=15 and holds. With SKID=0, out_ready=0 and occupancy=1 -> in_ready=0, and occupancy never reaches 2.
